// File: rtl/filter_16qam.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : filter_16qam                                                     |
// | Brief   : 16-QAM PRBS test transmitter with raised-cosine shaping and      |
// |           fs/4 digital IF mixer driving two signed DAC outputs.            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module filter_16qam #(
    parameter int BIT_DAC = 14,
    parameter int SPS     = 8,
    parameter int NTAPS   = 33,
    parameter int COEF_W  = 10,
    parameter int PATTERN = 0
) (
    input  logic                      clock_5000,
    input  logic                      reset,
    output logic signed [BIT_DAC-1:0] base_out,
    output logic signed [BIT_DAC-1:0] if_out
);

    localparam int c_CNT_W  = (SPS > 4) ? $clog2(SPS) : 2;
    localparam int c_LVL_W  = 3;
    localparam int c_CTR    = NTAPS / 2;
    localparam int c_PROD_W = c_LVL_W + 1 + COEF_W;
    localparam int c_ACC_W  = c_PROD_W + $clog2(c_CTR + 1) + 1;

    localparam logic signed [BIT_DAC-1:0] c_SAT_MAX = {1'b0, {(BIT_DAC-1){1'b1}}};
    localparam logic signed [BIT_DAC-1:0] c_SAT_MIN = {1'b1, {(BIT_DAC-1){1'b0}}};
    localparam logic        [8:0]         c_LFSR_SEED = 9'h1FF;

    // Raised cosine, roll-off 0.5, 511 full scale, indexed by distance from centre.
    function automatic logic signed [COEF_W-1:0] coef(input int k);
        int d;
        d = (k > c_CTR) ? (k - c_CTR) : (c_CTR - k);
        case (d)
            0:       coef = COEF_W'(511);
            1:       coef = COEF_W'(496);
            2:       coef = COEF_W'(453);
            3:       coef = COEF_W'(388);
            4:       coef = COEF_W'(307);
            5:       coef = COEF_W'(219);
            6:       coef = COEF_W'(134);
            7:       coef = COEF_W'(59);
            8:       coef = COEF_W'(0);
            9:       coef = COEF_W'(-41);
            10:      coef = COEF_W'(-63);
            11:      coef = COEF_W'(-68);
            12:      coef = COEF_W'(-61);
            13:      coef = COEF_W'(-47);
            14:      coef = COEF_W'(-29);
            15:      coef = COEF_W'(-13);
            default: coef = COEF_W'(0);
        endcase
    endfunction

    function automatic logic signed [c_LVL_W-1:0] gray_lvl(input logic [1:0] b);
        case (b)
            2'b00:   gray_lvl = -3'sd3;
            2'b01:   gray_lvl = -3'sd1;
            2'b11:   gray_lvl = 3'sd1;
            default: gray_lvl = 3'sd3;
        endcase
    endfunction

    function automatic logic signed [BIT_DAC-1:0] sat(input logic signed [c_ACC_W-1:0] v);
        if (v > c_ACC_W'(c_SAT_MAX)) begin
            sat = c_SAT_MAX;
        end else if (v < c_ACC_W'(c_SAT_MIN)) begin
            sat = c_SAT_MIN;
        end else begin
            sat = v[BIT_DAC-1:0];
        end
    endfunction

    function automatic logic signed [BIT_DAC-1:0] neg_sat(input logic signed [BIT_DAC-1:0] v);
        neg_sat = (v == c_SAT_MIN) ? c_SAT_MAX : -v;
    endfunction

    logic        [c_CNT_W-1:0] r_cnt;
    logic        [8:0]         r_lfsr;
    logic        [8:0]         w_lfsr_nxt;
    logic                      w_stb;
    logic signed [c_LVL_W-1:0] w_sym [2];
    logic signed [BIT_DAC-1:0] w_sat [2];
    logic signed [BIT_DAC-1:0] w_if;
    logic signed [BIT_DAC-1:0] r_base;
    logic signed [BIT_DAC-1:0] r_if;

    assign w_stb = (r_cnt == '0);

    always_ff @(posedge clock_5000 or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_W'(SPS - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // x^9 + x^5 + 1, bits leave at [8]; one symbol consumes four steps.
    always_comb begin
        w_lfsr_nxt = r_lfsr;
        for (int i = 0; i < 4; i++) begin
            w_lfsr_nxt = {w_lfsr_nxt[7:0], w_lfsr_nxt[8] ^ w_lfsr_nxt[4]};
        end
    end

    always_ff @(posedge clock_5000 or negedge reset) begin
        if (!reset) begin
            r_lfsr <= c_LFSR_SEED;
        end else if (w_stb) begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    generate
        if (PATTERN == 1) begin : g_const_sym
            assign w_sym[0] = 3'sd3;
            assign w_sym[1] = -3'sd3;
        end else begin : g_prbs_sym
            assign w_sym[0] = gray_lvl(r_lfsr[8:7]);
            assign w_sym[1] = gray_lvl(r_lfsr[6:5]);
        end
    endgenerate

    // Rail 0 carries I, rail 1 carries Q; each is a zero-stuffed symmetric FIR.
    generate
        for (genvar r = 0; r < 2; r++) begin : g_rail
            logic signed [c_LVL_W-1:0] r_dl [NTAPS];
            logic signed [c_ACC_W-1:0] w_acc;

            always_ff @(posedge clock_5000 or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < NTAPS; k++) begin
                        r_dl[k] <= '0;
                    end
                end else begin
                    r_dl[0] <= w_stb ? w_sym[r] : '0;
                    for (int k = 1; k < NTAPS; k++) begin
                        r_dl[k] <= r_dl[k-1];
                    end
                end
            end

            always_comb begin
                w_acc = c_ACC_W'(coef(c_CTR)) * c_ACC_W'(r_dl[c_CTR]);
                for (int k = 0; k < c_CTR; k++) begin
                    w_acc = w_acc + c_ACC_W'(coef(k))
                          * (c_ACC_W'(r_dl[k]) + c_ACC_W'(r_dl[NTAPS-1-k]));
                end
            end

            assign w_sat[r] = sat(w_acc);
        end
    endgenerate

    // fs/4 carrier: cos = 1,0,-1,0 and sin = 0,1,0,-1 over phases 0..3.
    always_comb begin
        w_if = w_sat[0];
        case (r_cnt[1:0])
            2'd0:    w_if = w_sat[0];
            2'd1:    w_if = neg_sat(w_sat[1]);
            2'd2:    w_if = neg_sat(w_sat[0]);
            default: w_if = w_sat[1];
        endcase
    end

    always_ff @(posedge clock_5000 or negedge reset) begin
        if (!reset) begin
            r_base <= '0;
            r_if   <= '0;
        end else begin
            r_base <= w_sat[0];
            r_if   <= w_if;
        end
    end

    assign base_out = r_base;
    assign if_out   = r_if;

endmodule
`default_nettype wire

// File: tb/tb_filter_16qam.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_filter_16qam                                                  |
// | Brief   : Scoreboard bench for filter_16qam, PRBS and constant-symbol cores|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_filter_16qam;

    localparam int BIT_DAC  = 14;
    localparam int SPS      = 8;
    localparam int NTAPS    = 33;
    localparam int NSYM_RUN = 4096;
    localparam int MAXSYM   = 4200;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic signed [BIT_DAC-1:0] base0, if0, base1, if1;

    always #10 clk = ~clk;

    filter_16qam #(.PATTERN(0)) u_dut_prbs (
        .clock_5000 (clk),
        .reset      (rst_n),
        .base_out   (base0),
        .if_out     (if0)
    );

    filter_16qam #(.PATTERN(1)) u_dut_const (
        .clock_5000 (clk),
        .reset      (rst_n),
        .base_out   (base1),
        .if_out     (if1)
    );

    typedef struct {
        int b0;
        int f0;
        int b1;
        int f1;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   h [NTAPS];
    int   lvl_i [MAXSYM];
    int   lvl_q [MAXSYM];
    bit   obit [MAXSYM*4+16];

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic real rc(input real t);
        real pi;
        pi = 3.14159265358979;
        if (t == 0.0) return 1.0;
        if (t == 1.0 || t == -1.0) return 0.0;
        return ($sin(pi*t) / (pi*t)) * $cos(pi*0.5*t) / (1.0 - t*t);
    endfunction

    function automatic int gray(input int b);
        case (b)
            0:       return -3;
            1:       return -1;
            3:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int clamp(input int v);
        if (v > 8191) return 8191;
        if (v < -8192) return -8192;
        return v;
    endfunction

    // Output registered at edge t sees symbol j on tap k = t-1-SPS*j.
    function automatic int fir(input int t, input int rail, input bit cst);
        int acc;
        int j;
        acc = 0;
        if (t >= 1) begin
            for (int k = (t-1) % SPS; k < NTAPS && k <= t-1; k += SPS) begin
                j = (t-1-k) / SPS;
                if (cst) acc += h[k] * ((rail == 0) ? 3 : -3);
                else     acc += h[k] * ((rail == 0) ? lvl_i[j] : lvl_q[j]);
            end
        end
        return clamp(acc);
    endfunction

    function automatic int mix(input int t, input bit cst);
        case (t % 4)
            0:       return fir(t, 0, cst);
            1:       return clamp(-fir(t, 1, cst));
            2:       return clamp(-fir(t, 0, cst));
            default: return fir(t, 1, cst);
        endcase
    endfunction

    task automatic build_model();
        real v;
        for (int k = 0; k < NTAPS; k++) begin
            v = 511.0 * rc(real'(k - 16) / real'(SPS));
            h[k] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        end
        for (int i = 0; i < 9; i++) obit[i] = 1'b1;
        for (int i = 0; i + 9 < MAXSYM*4+16; i++) obit[i+9] = obit[i] ^ obit[i+4];
        for (int j = 0; j < MAXSYM; j++) begin
            lvl_i[j] = gray(2*int'(obit[4*j])   + int'(obit[4*j+1]));
            lvl_q[j] = gray(2*int'(obit[4*j+2]) + int'(obit[4*j+3]));
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_base0"}, base0, 0);
        check_val({tag, "_if0"},   if0,   0);
        check_val({tag, "_base1"}, base1, 0);
        check_val({tag, "_if1"},   if1,   0);
    endtask

    // Cycle 0 is the cycle following reset release.
    task automatic run_cycles(input int ncyc);
        exp_t e;
        for (int t = 0; t < ncyc; t++) begin
            e.b0 = fir(t, 0, 1'b0);
            e.f0 = mix(t, 1'b0);
            e.b1 = fir(t, 0, 1'b1);
            e.f1 = mix(t, 1'b1);
            sb.push_back(e);
            @(posedge clk);
            @(negedge clk);
            if (sb.size() == 0) begin
                check_val("sb_empty", 0, 1);
            end else begin
                e = sb.pop_front();
                check_val("base_prbs",  base0, e.b0);
                check_val("if_prbs",    if0,   e.f0);
                check_val("base_const", base1, e.b1);
                check_val("if_const",   if1,   e.f1);
            end
            if (t == 17) begin
                check_val("first_sym_centre", base0, 511);
            end
            if (t >= 33 && (t % SPS) == 1) begin
                check_val("const_centre_base", base1, 1533);
                check_val("const_centre_if",   if1,   1533);
            end
        end
    endtask

    initial begin
        build_model();
        rst_n = 1'b0;
        #15;
        check_zero("rst_hold");
        #5  rst_n = 1'b1;
        #5  rst_n = 1'b0;
        #1;
        check_zero("rst_pulse");
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(200);

        @(posedge clk);
        #5 rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(NSYM_RUN * SPS + 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
